lcd_timing_gen: RTL and testbench

- Pixel-clock display timing generator that sits directly downstream of the video DMA read port.
- Generates the read-request strobe (o_rd_video_valid) and the frame/field marker that the DMA read channel consumes.
- Realigns returned pixel data with LCD HS/VS/DE and emits a panel-ready RGB stream.
- Also checks that the DMA's line_last marker lands on the last active pixel of each line.

---
 rtl/lcd_timing_gen.sv | 181 ++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - LCD HS/VS/DE timing generator with DMA read strobes and pixel realignment
// Optional colour-bar source: define LCD_TIMING_GEN_TEST_PATTERN_EN.
module lcd_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 21,
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = 16,
    parameter int SYNC_POL   = 0
) (
    input  logic                  i_video_clk,
    input  logic                  i_video_rstn,
    input  logic                  i_enable,
`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
    input  logic                  i_pattern_sel,
`endif
    output logic [15:0]           o_rd_video_width,
    output logic [15:0]           o_rd_video_high,
    output logic                  o_rd_video_field,
    output logic                  o_rd_video_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_video_data,
    input  logic                  i_rd_video_line_last,
    output logic                  o_lcd_hs,
    output logic                  o_lcd_vs,
    output logic                  o_lcd_de,
    output logic [DATA_WIDTH-1:0] o_lcd_data,
    output logic                  o_align_err
);

    localparam logic [15:0] H_ACT16  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT16  = 16'(V_ACTIVE);
    localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_IDLE = (SYNC_POL == 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_h_cnt, r_v_cnt;
    logic        w_run, w_h_last, w_v_last, w_frame_end;
    logic        w_de0, w_hs0, w_vs0, w_last0;
    logic        r_de1, r_hs1, r_vs1, r_last1;
    logic [3:0]  r_sr [RD_LATENCY];
    logic        w_tap_hs, w_tap_vs, w_tap_de, w_tap_last;
    logic        w_align_bad, w_pat_on;
    logic [DATA_WIDTH-1:0] w_pix;

    assign o_rd_video_width = H_ACT16;
    assign o_rd_video_high  = V_ACT16;

    assign w_run       = (r_state == S_RUN);
    assign w_h_last    = (r_h_cnt == H_TOTAL - 16'd1);
    assign w_v_last    = (r_v_cnt == V_TOTAL - 16'd1);
    assign w_frame_end = w_run && w_h_last && w_v_last;

    always_ff @(posedge i_video_clk) begin
        if (!i_video_rstn) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    // Stopping is only honoured on the last clock of a frame, so frames are never cut short.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_enable) w_state_nxt = S_RUN;
            S_RUN:   if (w_frame_end && !i_enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_video_clk) begin
        if (!i_video_rstn || r_state == S_IDLE) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 16'd0 : r_v_cnt + 16'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 16'd1;
        end
    end

    assign w_de0   = w_run && (r_h_cnt < H_ACT16) && (r_v_cnt < V_ACT16);
    assign w_hs0   = w_run && (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vs0   = w_run && (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
    assign w_last0 = w_de0 && (r_h_cnt == H_ACT16 - 16'd1);

    // Stage 1 doubles as the DMA strobe; the shift register then waits out the read latency.
    always_ff @(posedge i_video_clk) begin
        if (!i_video_rstn) begin
            r_de1   <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_last1 <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) r_sr[i] <= '0;
        end else begin
            r_de1   <= w_de0;
            r_hs1   <= w_hs0;
            r_vs1   <= w_vs0;
            r_last1 <= w_last0;
            r_sr[0] <= {r_hs1, r_vs1, r_de1, r_last1};
            for (int i = 1; i < RD_LATENCY; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign {w_tap_hs, w_tap_vs, w_tap_de, w_tap_last} = r_sr[RD_LATENCY-1];
    assign o_rd_video_valid = r_de1 && !w_pat_on;
    assign o_rd_video_field = r_vs1;

`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
    logic                  r_pat;
    logic [15:0]           r_h1;
    logic [15:0]           r_sr_h [RD_LATENCY];
    logic [2:0]            w_bar_idx;
    logic [DATA_WIDTH-1:0] w_bar_color;

    always_ff @(posedge i_video_clk) begin
        if (!i_video_rstn) begin
            r_pat <= 1'b0;
            r_h1  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) r_sr_h[i] <= '0;
        end else begin
            if ((r_state == S_IDLE && i_enable) || w_frame_end) r_pat <= i_pattern_sel;
            r_h1      <= r_h_cnt;
            r_sr_h[0] <= r_h1;
            for (int i = 1; i < RD_LATENCY; i++) r_sr_h[i] <= r_sr_h[i-1];
        end
    end

    assign w_pat_on  = r_pat;
    assign w_bar_idx = 3'((32'(r_sr_h[RD_LATENCY-1]) * 32'd8) / 32'(H_ACTIVE));

    always_comb begin
        w_bar_color = '0;
        case (w_bar_idx)
            3'd0: w_bar_color = DATA_WIDTH'(16'hFFFF);
            3'd1: w_bar_color = DATA_WIDTH'(16'hFFE0);
            3'd2: w_bar_color = DATA_WIDTH'(16'h07FF);
            3'd3: w_bar_color = DATA_WIDTH'(16'h07E0);
            3'd4: w_bar_color = DATA_WIDTH'(16'hF81F);
            3'd5: w_bar_color = DATA_WIDTH'(16'hF800);
            3'd6: w_bar_color = DATA_WIDTH'(16'h001F);
            default: w_bar_color = '0;
        endcase
    end

    assign w_pix = w_pat_on ? w_bar_color : i_rd_video_data;
`else
    assign w_pat_on = 1'b0;
    assign w_pix    = i_rd_video_data;
`endif

    // line_last must coincide exactly with the delayed last-pixel flag; a stray marker outside DE also counts.
    assign w_align_bad = w_tap_de ? (i_rd_video_line_last != w_tap_last) : i_rd_video_line_last;

    always_ff @(posedge i_video_clk) begin
        if (!i_video_rstn) begin
            o_lcd_de    <= 1'b0;
            o_lcd_hs    <= SYNC_IDLE;
            o_lcd_vs    <= SYNC_IDLE;
            o_lcd_data  <= '0;
            o_align_err <= 1'b0;
        end else begin
            o_lcd_de    <= w_tap_de;
            o_lcd_hs    <= w_tap_hs ? ~SYNC_IDLE : SYNC_IDLE;
            o_lcd_vs    <= w_tap_vs ? ~SYNC_IDLE : SYNC_IDLE;
            o_lcd_data  <= w_tap_de ? w_pix : '0;
            o_align_err <= o_align_err | (w_align_bad & ~w_pat_on);
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - directed scoreboard bench for lcd_timing_gen with a loopback DMA model
module tb_lcd_timing_gen;

    localparam int FR = 98;

    logic        clk = 1'b0;
    logic        rstn, en, line_last;
    logic [15:0] rd_data;
    logic [15:0] rd_width, rd_high;
    logic        rd_field, rd_valid, lcd_hs, lcd_vs, lcd_de, align_err;
    logic [15:0] lcd_data;
`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
    logic        pat_sel;
`endif

    int          cyc, n_vec, n_err, nv_cnt, c0, prev_idx, idx;
    bit          prev_valid, bad, sb_en, err_exp;
    logic [15:0] sb_q [$];

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .RD_LATENCY(1), .DATA_WIDTH(16), .SYNC_POL(0)
    ) dut (
        .i_video_clk          (clk),
        .i_video_rstn         (rstn),
        .i_enable             (en),
`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
        .i_pattern_sel        (pat_sel),
`endif
        .o_rd_video_width     (rd_width),
        .o_rd_video_high      (rd_high),
        .o_rd_video_field     (rd_field),
        .o_rd_video_valid     (rd_valid),
        .i_rd_video_data      (rd_data),
        .i_rd_video_line_last (line_last),
        .o_lcd_hs             (lcd_hs),
        .o_lcd_vs             (lcd_vs),
        .o_lcd_de             (lcd_de),
        .o_lcd_data           (lcd_data),
        .o_align_err          (align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; drive the DMA return for last cycle's request and run the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_valid) begin
            rd_data   = 16'(prev_idx);
            line_last = bad ? (prev_idx == 6) : (prev_idx == 7);
        end else begin
            rd_data   = '0;
            line_last = 1'b0;
        end
        prev_valid = (rd_valid === 1'b1);
        if (prev_valid) begin
            prev_idx = idx;
            sb_q.push_back(16'(idx));
            idx = (idx + 1) % 8;
        end
        if (sb_en && lcd_de === 1'b1) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("sb_data", 32'(lcd_data), 32'(sb_q.pop_front()));
        end
    endtask

    function automatic bit in_run(int off, int nfr);
        return (off >= 0) && (off < nfr * FR);
    endfunction

    function automatic bit m_valid(int off, int nfr);
        if (!in_run(off, nfr)) return 1'b0;
        return ((off % 14) < 8) && (((off % FR) / 14) < 4);
    endfunction

    function automatic bit m_vsync(int off, int nfr);
        if (!in_run(off, nfr)) return 1'b0;
        return ((off % FR) / 14) == 5;
    endfunction

    function automatic bit m_hsync(int off, int nfr);
        if (!in_run(off, nfr)) return 1'b0;
        return ((off % 14) >= 10) && ((off % 14) < 12);
    endfunction

    // off counts cycles from the first read strobe of the run; LCD outputs lag the strobe by 2.
    task automatic run_frames(input int first, input int last, input int nfr,
                              input int drop_off, input int bad_off);
        bit de_x;
        int ho;
        for (int off = first; off <= last; off++) begin
            if (off == drop_off) en = 1'b0;
            if (off == bad_off) bad = 1'b1;
            de_x = m_valid(off - 2, nfr);
            ho   = de_x ? (off - 2) % 14 : 0;
            if (bad_off >= 0 && off >= bad_off + 2 && de_x && ho == 6) err_exp = 1'b1;
            if (off < FR && rd_valid === 1'b1) nv_cnt++;
            check("rd_valid",  32'(rd_valid),  32'(m_valid(off, nfr)));
            check("rd_field",  32'(rd_field),  32'(m_vsync(off, nfr)));
            check("lcd_de",    32'(lcd_de),    32'(de_x));
            check("lcd_hs",    32'(lcd_hs),    32'(!m_hsync(off - 2, nfr)));
            check("lcd_vs",    32'(lcd_vs),    32'(!m_vsync(off - 2, nfr)));
            check("lcd_data",  32'(lcd_data),  32'(ho));
            check("align_err", 32'(align_err), 32'(err_exp));
            tick();
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_valid"}, 32'(rd_valid),  32'd0);
        check({pfx, "_field"}, 32'(rd_field),  32'd0);
        check({pfx, "_de"},    32'(lcd_de),    32'd0);
        check({pfx, "_data"},  32'(lcd_data),  32'd0);
        check({pfx, "_hs"},    32'(lcd_hs),    32'd1);
        check({pfx, "_vs"},    32'(lcd_vs),    32'd1);
        check({pfx, "_err"},   32'(align_err), 32'd0);
    endtask

    task automatic start_and_sync();
        en = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 10 && rd_valid !== 1'b1; k++) tick();
        check("first_valid_latency", 32'(cyc - c0), 32'd2);
    endtask

`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; nv_cnt = 0; idx = 0; prev_idx = 0;
        prev_valid = 0; bad = 0; sb_en = 1; err_exp = 0;
        rstn = 1'b0; en = 1'b0; rd_data = '0; line_last = 1'b0;
`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
        pat_sel = 1'b0;
`endif
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check_reset_state("rst");
        check("width", 32'(rd_width), 32'd8);
        check("high",  32'(rd_high),  32'd4);

        // Two clean frames, two with line_last on pixel 6, then a stop requested at h=3, v=1.
        start_and_sync();
        nv_cnt = 0;
        run_frames(0, 5 * FR + 39, 5, 4 * FR + 16, 2 * FR);
        check("valid_pulses_frame0", 32'(nv_cnt), 32'd32);
        bad = 1'b0;

        // One-clock reset in the middle of a pixel burst.
        start_and_sync();
        run_frames(0, 4, 100, -1, -1);
        check("err_before_reset", 32'(align_err), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_state("midrst");
        sb_q.delete();
        idx = 0;
        err_exp = 1'b0;
        tick();
        check("restart_valid_t1", 32'(rd_valid), 32'd0);
        tick();
        check("restart_valid_t2", 32'(rd_valid), 32'd1);
        nv_cnt = 0;
        run_frames(0, FR - 1, 100, -1, -1);
        check("valid_pulses_restart", 32'(nv_cnt), 32'd32);

`ifdef LCD_TIMING_GEN_TEST_PATTERN_EN
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        sb_en = 1'b0;
        pat_sel = 1'b1;
        en = 1'b1;
        begin
            int k;
            for (k = 0; k < 300 && lcd_de !== 1'b1; k++) begin
                check("pat_valid_forced", 32'(rd_valid), 32'd0);
                tick();
            end
            if (lcd_de !== 1'b1) check("pat_de_timeout", 32'd0, 32'd1);
            for (int j = 0; j < 8; j++) begin
                check("pat_bar", 32'(lcd_data), 32'(bars[j]));
                check("pat_valid_forced", 32'(rd_valid), 32'd0);
                check("pat_err", 32'(align_err), 32'd0);
                tick();
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
